alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Two-port sequencer that shares the single 4-bit combinational ALU (8 ops: add, sub, not, and, or, xor, signed-compare, equal) between two requesters.
- Each requester submits an operand/op bundle over a valid/ready handshake. The block grants one requester round-robin, drives the ALU, registers result and flags, and returns them over a per-requester response handshake.
- Sits between requester logic (switch front-end, test sequencer) and the ALU instance.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  3  requester 0 ALU op code (000 add … 111 equal).
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as the req0 ports, for requester 1.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_ctrl  out  3  registered op to the ALU.
- alu_res  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- alu_car, alu_of  in  1  ALU carry and overflow.
- rsp0_valid, rsp1_valid  out  1  response for requester 0/1 is pending.
- rsp0_ready, rsp1_ready  in  1  requester 0/1 consumes the response.
- rsp_res  out  WIDTH  shared response result.
- rsp_car, rsp_of  out  1  shared response flags.
- rsp_id  out  1  owner of the current response (0/1).
- op_count  out  CNT_W  completed operations, saturating.

Behaviour:
- Clocking and reset: one clock; reset asynchronous, active-low (rst_n).
- Reset values: state IDLE; prio=0; alu_a, alu_b, alu_ctrl = 0; rsp0_valid, rsp1_valid = 0; rsp_res = 0, rsp_car = 0, rsp_of = 0, rsp_id = 0; op_count = 0. Assertion mid-operation aborts immediately; the in-flight command and any pending response are discarded.
- FSM states: IDLE, EXEC, RESP.
- Grant (IDLE only):
  - Only reqN_valid high -> grant N.
  - Both high -> grant prio.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational; at most one ready per cycle.
- IDLE -> EXEC on any accept (valid & ready):
  - latch operands/op into alu_a, alu_b, alu_ctrl;
  - latch owner;
  - prio <= ~owner.
- EXEC, exactly 1 cycle:
  - sample alu_res, alu_car, alu_of into the rsp_* registers;
  - rsp_id <= owner; rsp<owner>_valid <= 1;
  - op_count increments unless at all-ones (saturate, no wrap);
  - -> RESP.
- RESP:
  - hold rsp_* and rsp<owner>_valid stable until rsp<owner>_ready is high;
  - on that edge clear valid, -> IDLE;
  - the other requester's rsp_ready is ignored.
- Latency: accept at edge T; ALU driven during cycle T+1; rspN_valid high from edge T+2. Minimum issue interval 3 cycles (next accept at earliest the cycle after response consumption).
- alu_a, alu_b, alu_ctrl hold their last values in IDLE/RESP; no glitching from unaccepted requests.
- Request inputs are sampled only at accept; later changes are ignored.
- Fairness:
  - prio toggles only on grant, so back-to-back contention alternates 0,1,0,1.
  - A lone requester may be granted repeatedly.
- Never both rsp0_valid and rsp1_valid high.

Test Plan:
- Reset then req0 add a=4'h7, b=4'h1, rsp0_ready=1 -> req0_ready at T; rsp0_valid at T+2 with rsp_res=4'h8, rsp_car=0, rsp_of=1, rsp_id=0; op_count=1.
- req0 and req1 both valid continuously, 4 ops (req0 sub 3-5, req1 xor A^F) -> grant order 0,1,0,1; rsp_res 4'hE (car=0) and 4'h5 alternating.
- req1 equal a=b=4'h9 with rsp1_ready held low 5 cycles -> rsp1_valid and rsp_res=0 stable for 5 cycles; no req ready during hold; req0 valid meanwhile stays unaccepted.
- rst_n dropped during EXEC (asynchronously, mid-cycle) -> all outputs zero immediately; after release, no response is emitted for the aborted command.
- Force op_count near saturation (255 ops, CNT_W=8), issue 2 more -> op_count stays 8'hFF.
- req0 operands changed during EXEC -> rsp_res reflects the operands latched at accept only.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Accept -> one EXEC cycle driving the ALU -> response held until consumed by its owner.
module alu_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_car,
  output logic             rsp_of,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_car_q, rsp_car_d;
  logic             rsp_of_q, rsp_of_d;
  logic             rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             grant_c;
  logic             accept_c;
  logic             own_rsp_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_res_q    <= '0;
      rsp_car_q    <= 1'b0;
      rsp_of_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_res_q    <= rsp_res_d;
      rsp_car_q    <= rsp_car_d;
      rsp_of_q     <= rsp_of_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp_res_d    = rsp_res_q;
    rsp_car_d    = rsp_car_q;
    rsp_of_d     = rsp_of_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;

    // Lone requester wins outright; contention goes to prio.
    grant_c = prio_q;
    if (req0_valid && !req1_valid) grant_c = 1'b0;
    else if (req1_valid && !req0_valid) grant_c = 1'b1;

    req0_ready      = (state_q == IDLE) && !grant_c;
    req1_ready      = (state_q == IDLE) && grant_c;
    accept_c        = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    own_rsp_ready_c = owner_q ? rsp1_ready : rsp0_ready;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          alu_a_d    = grant_c ? req1_a  : req0_a;
          alu_b_d    = grant_c ? req1_b  : req0_b;
          alu_ctrl_d = grant_c ? req1_op : req0_op;
          owner_d    = grant_c;
          prio_d     = !grant_c;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d = alu_res;
        rsp_car_d = alu_car;
        rsp_of_d  = alu_of;
        rsp_id_d  = owner_q;
        if (owner_q) rsp1_valid_d = 1'b1;
        else         rsp0_valid_d = 1'b1;
        if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + CNT_W'(1);
        state_d = RESP;
      end
      RESP: begin
        if (own_rsp_ready_c) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_res    = rsp_res_q;
  assign rsp_car    = rsp_car_q;
  assign rsp_of     = rsp_of_q;
  assign rsp_id     = rsp_id_q;
  assign op_count   = op_count_q;

endmodule
